prbs_axis_mapper: RTL and testbench
===================================

Name: prbs_axis_mapper

Overview:
- Downstream of the lfsr stimulus generator; feeds the AXI-Stream Red Pitaya DAC core.
- Consumes the lfsr chip stream (sig_o as bit_i, plus period flag_o as flag_i) qualified by a per-chip strobe.
- Maps each chip to a signed bipolar DAC sample of programmable amplitude and buffers it in a small FIFO.
- Presents samples as an AXI-Stream master with tlast marking the last chip of each PRBS period.

Parameters:
- FIFO_DEPTH, 8, sample FIFO depth; power of two, 4..64.
- DAC_W, 14, DAC sample width in bits; tdata is DAC_W sign-extended to 16 bits.
- CNT_W, 16, width of the period counter.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- srst  in  1  asynchronous, active-high reset.
- en  in  1  run enable; chips are accepted only while high.
- bit_i  in  1  PRBS chip from lfsr sig_o.
- flag_i  in  1  chip is the last of a PRBS period (lfsr flag_o).
- bit_vld_i  in  1  one-cycle strobe qualifying bit_i and flag_i.
- amp_i  in  DAC_W-1  unsigned amplitude magnitude, 0..2^(DAC_W-1)-1.
- m_axis_tdata  out  16  signed sample.
- m_axis_tvalid  out  1  AXIS valid.
- m_axis_tready  in  1  AXIS ready.
- m_axis_tlast  out  1  last sample of a PRBS period.
- ovf_o  out  1  sticky flag: a chip was dropped because the FIFO was full.
- busy_o  out  1  high when the state is not IDLE.
- period_cnt_o  out  CNT_W  count of completed periods transferred (tlast handshakes).

Behaviour:
- Reset values (srst high, asynchronous): all outputs 0, FIFO empty, state IDLE, amp_q = 0.
- State machine:
  - IDLE -> RUN when en = 1. On this transition: period_cnt_o clears to 0 and amp_q <= amp_i.
  - RUN -> DRAIN when en = 0 and the FIFO is non-empty.
  - RUN -> IDLE when en = 0 and the FIFO is empty.
  - DRAIN -> IDLE when the FIFO is empty.
  - DRAIN -> RUN when en returns to 1. amp_q is not reloaded and period_cnt_o is not cleared.
- Accept condition: chip accepted when bit_vld_i = 1, en = 1, state is RUN or IDLE->RUN in that cycle, and a FIFO slot is available.
- Chips with en = 0 are silently ignored and do not set ovf_o.
- Mapping:
  - bit_i = 1 -> +amp_q; bit_i = 0 -> -amp_q.
  - Two's complement at DAC_W bits, sign-extended to 16 bits.
  - amp_q = 0 gives 0x0000 for both chip values.
- Amplitude update: amp_q <= amp_i on the cycle an accepted chip has flag_i = 1, taking effect from the next chip. Amplitude therefore changes only on period boundaries.
- FIFO entry = {flag_i, sample}. Output is first-word-fall-through:
  - m_axis_tvalid = FIFO not empty.
  - tdata and tlast show the head entry.
  - Latency: chip accepted in cycle N -> tvalid high in cycle N+1 when the FIFO was empty.
- Handshake:
  - Entry pops on tvalid && tready.
  - tdata and tlast stay stable while tvalid && !tready.
  - tvalid never drops without a pop, except on srst.
- Full boundary: a slot is available when count < FIFO_DEPTH, or count = FIFO_DEPTH with a pop in the same cycle.
  - Simultaneous push and pop leaves count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- Overflow: a qualifying chip with no slot is dropped and ovf_o is set. ovf_o clears only on srst.
- Empty boundary: pop never occurs when empty; tready with an empty FIFO has no effect.
- period_cnt_o increments on each handshake with tlast = 1 and wraps modulo 2^CNT_W.
- srst mid-operation: FIFO contents discarded, tvalid low on the next edge, all state returns to reset values.

Test Plan:
- Reset, then en = 1, amp_i = 1000, tready = 1, chips 1,0,1 with flag on the third -> tdata 0x03E8, 0xFC18, 0x03E8; tlast on the third sample only; period_cnt_o = 1; tvalid rises one cycle after the first strobe.
- tready = 0, push 9 chips with FIFO_DEPTH = 8 -> ovf_o = 1 after the 9th; then tready = 1 -> exactly 8 samples out, in order; ovf_o stays 1.
- FIFO full with tready = 1 and a strobe in the same cycle -> chip accepted, ovf_o stays 0, count stays 8.
- amp_i changed 1000 -> 2000 mid-period -> samples keep +/-1000 until after the flagged chip, then +/-2000.
- en drops with 5 entries queued -> busy_o stays high (DRAIN), all 5 drain, then IDLE and busy_o = 0; strobes while en = 0 are ignored.
- srst asserted asynchronously with 3 entries queued and tready = 0 -> all outputs 0 immediately; after release, no stale samples appear.

Source files
------------

// File: rtl/prbs_axis_mapper.sv
// prbs_axis_mapper: maps PRBS chips to signed bipolar DAC samples on an AXI-Stream master.
// Latency: a chip accepted in cycle N is presented (tvalid high) in cycle N+1 if the FIFO was empty.
// Backpressure: m_axis_tready stalls the FIFO; chips arriving with no free slot are dropped and flagged in ovf_o.

// Small first-word-fall-through FIFO. The owner guarantees that push is never
// requested on a full FIFO unless a pop happens in the same cycle.
module prbs_axis_mapper_fifo #(
  parameter int W     = 17,
  parameter int DEPTH = 8,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          srst,
  input  logic          push_i,
  input  logic [W-1:0]  dat_i,
  input  logic          pop_i,
  output logic [W-1:0]  dat_o,
  output logic [CW-1:0] cnt_o,
  output logic          empty_o
);

  localparam int AW = CW - 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          pop_ok;

  // A pop on an empty FIFO is meaningless and is ignored.
  assign pop_ok  = pop_i && (cnt_q != '0);
  assign empty_o = (cnt_q == '0);
  assign cnt_o   = cnt_q;
  assign dat_o   = mem_q[rd_ptr_q];

  // Pointer and occupancy next-state; pointers wrap naturally since DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push_i) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({push_i, pop_ok})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Pointer and occupancy registers; reset discards all contents.
  always_ff @(posedge clk or posedge srst) begin
    if (srst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage array; needs no reset because reads are only meaningful when non-empty.
  always_ff @(posedge clk) begin
    if (push_i) begin
      mem_q[wr_ptr_q] <= dat_i;
    end
  end

endmodule

module prbs_axis_mapper #(
  parameter int FIFO_DEPTH = 8,
  parameter int DAC_W      = 14,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             en,
  input  logic             bit_i,
  input  logic             flag_i,
  input  logic             bit_vld_i,
  input  logic [DAC_W-2:0] amp_i,
  output logic [15:0]      m_axis_tdata,
  output logic             m_axis_tvalid,
  input  logic             m_axis_tready,
  output logic             m_axis_tlast,
  output logic             ovf_o,
  output logic             busy_o,
  output logic [CNT_W-1:0] period_cnt_o
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [DAC_W-2:0] amp_q, amp_d;
  logic             ovf_q, ovf_d;
  logic [CNT_W-1:0] period_q, period_d;

  logic             start;
  logic             chip_elig;
  logic             slot_avail;
  logic             push;
  logic             pop;
  logic [DAC_W-2:0] amp_eff;
  logic [DAC_W-1:0] mag;
  logic [DAC_W-1:0] smp;
  logic [15:0]      smp16;

  logic [16:0]      fifo_wdat;
  logic [16:0]      fifo_rdat;
  logic [CW-1:0]    fifo_cnt;
  logic             fifo_empty;

  // Leaving IDLE this cycle; the same cycle may already accept a chip.
  assign start = (state_q == ST_IDLE) && en;

  // Chips are only considered while enabled and in RUN (or entering it from IDLE).
  // A chip arriving while DRAIN is being left is not taken.
  assign chip_elig = bit_vld_i && en && ((state_q == ST_RUN) || (state_q == ST_IDLE));

  // FWFT handshake: the head entry leaves whenever the consumer is ready.
  assign pop = !fifo_empty && m_axis_tready;

  // A full FIFO still takes a chip if the head leaves in the same cycle.
  assign slot_avail = (fifo_cnt != CW'(FIFO_DEPTH)) || pop;
  assign push       = chip_elig && slot_avail;

  // On the IDLE->RUN cycle amp_q is only being loaded, so use the incoming
  // value directly; otherwise the registered amplitude applies.
  assign amp_eff = (state_q == ST_IDLE) ? amp_i : amp_q;

  // Bipolar mapping: chip 1 -> +amp, chip 0 -> -amp, two's complement at DAC_W bits.
  assign mag   = {1'b0, amp_eff};
  assign smp   = bit_i ? mag : (DAC_W'(0) - mag);
  assign smp16 = 16'($signed(smp));

  assign fifo_wdat = {flag_i, smp16};

  prbs_axis_mapper_fifo #(
    .W     (17),
    .DEPTH (FIFO_DEPTH),
    .CW    (CW)
  ) u_fifo (
    .clk     (clk),
    .srst    (srst),
    .push_i  (push),
    .dat_i   (fifo_wdat),
    .pop_i   (pop),
    .dat_o   (fifo_rdat),
    .cnt_o   (fifo_cnt),
    .empty_o (fifo_empty)
  );

  // Output data is forced to zero while empty so stale storage never shows.
  assign m_axis_tvalid = !fifo_empty;
  assign m_axis_tdata  = fifo_empty ? 16'h0000 : fifo_rdat[15:0];
  assign m_axis_tlast  = !fifo_empty && fifo_rdat[16];
  assign ovf_o         = ovf_q;
  assign busy_o        = (state_q != ST_IDLE);
  assign period_cnt_o  = period_q;

  // Run/drain control: disabling with data queued lets the FIFO empty before idling.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (en) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (!en) begin
          state_d = fifo_empty ? ST_IDLE : ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (en) begin
          state_d = ST_RUN;
        end else if (fifo_empty) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Amplitude is captured at start and otherwise only at period boundaries,
  // so a period is never split between two amplitudes.
  always_comb begin
    amp_d = amp_q;
    if (start) begin
      amp_d = amp_i;
    end else if (push && flag_i) begin
      amp_d = amp_i;
    end
  end

  // Sticky overflow: an eligible chip found no room in the FIFO.
  always_comb begin
    ovf_d = ovf_q;
    if (chip_elig && !slot_avail) begin
      ovf_d = 1'b1;
    end
  end

  // Completed periods are counted as they leave on the stream, cleared at start.
  always_comb begin
    period_d = period_q;
    if (start) begin
      period_d = '0;
    end else if (pop && fifo_rdat[16]) begin
      period_d = period_q + CNT_W'(1);
    end
  end

  // Control registers with asynchronous reset.
  always_ff @(posedge clk or posedge srst) begin
    if (srst) begin
      state_q  <= ST_IDLE;
      amp_q    <= '0;
      ovf_q    <= 1'b0;
      period_q <= '0;
    end else begin
      state_q  <= state_d;
      amp_q    <= amp_d;
      ovf_q    <= ovf_d;
      period_q <= period_d;
    end
  end

endmodule

// File: tb/tb_prbs_axis_mapper.sv
// Testbench for prbs_axis_mapper: directed scenarios plus a randomized run,
// checked every cycle against a queue-based reference model of the stream.
// Outputs are sampled 1 time unit after each rising edge.
module tb_prbs_axis_mapper;

  localparam int DEPTH = 8;
  localparam int DAC_W = 14;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             srst;
  logic             en;
  logic             bit_i;
  logic             flag_i;
  logic             bit_vld_i;
  logic [DAC_W-2:0] amp_i;
  logic [15:0]      m_axis_tdata;
  logic             m_axis_tvalid;
  logic             m_axis_tready;
  logic             m_axis_tlast;
  logic             ovf_o;
  logic             busy_o;
  logic [CNT_W-1:0] period_cnt_o;

  always #5 clk = ~clk;

  prbs_axis_mapper #(
    .FIFO_DEPTH (DEPTH),
    .DAC_W      (DAC_W),
    .CNT_W      (CNT_W)
  ) dut (
    .clk           (clk),
    .srst          (srst),
    .en            (en),
    .bit_i         (bit_i),
    .flag_i        (flag_i),
    .bit_vld_i     (bit_vld_i),
    .amp_i         (amp_i),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .ovf_o         (ovf_o),
    .busy_o        (busy_o),
    .period_cnt_o  (period_cnt_o)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: mode 0 = idle, 1 = running, 2 = draining.
  // Each queue entry is (last << 16) | 16-bit sample.
  int          mode;
  int          amp_m;
  int          q[$];
  bit          ovf_m;
  int unsigned per_m;

  // Samples actually handed over by the DUT, same encoding as q.
  int dut_out[$];

  int exp1[3] = '{32'h003E8, 32'h0FC18, 32'h103E8};
  int exp4[6] = '{32'h003E8, 32'h003E8, 32'h003E8, 32'h103E8, 32'h0F830, 32'h007D0};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  function automatic void model_reset();
    mode  = 0;
    amp_m = 0;
    q.delete();
    ovf_m = 1'b0;
    per_m = 0;
  endfunction

  // One clock edge of the model, from the inputs currently being driven.
  function automatic void model_step();
    int n0;
    bit pop;
    bit elig;
    bit space;
    int a;
    int s;
    int h;
    n0    = q.size();
    pop   = (n0 > 0) && m_axis_tready;
    elig  = bit_vld_i && en && (mode != 2);
    space = (n0 < DEPTH) || pop;
    a     = (mode == 0) ? int'(amp_i) : amp_m;
    if (pop) begin
      h = q.pop_front();
      if (h >= 32'h10000) per_m = (per_m + 1) % 65536;
    end
    if (elig && space) begin
      s = bit_i ? a : -a;
      q.push_back((int'(flag_i) << 16) | (s & 32'hFFFF));
    end
    if (elig && !space) ovf_m = 1'b1;
    if (mode == 0 && en) begin
      amp_m = int'(amp_i);
      per_m = 0;
    end else if (elig && space && flag_i) begin
      amp_m = int'(amp_i);
    end
    case (mode)
      0: if (en) mode = 1;
      1: if (!en) mode = (n0 > 0) ? 2 : 0;
      default: begin
        if (en) mode = 1;
        else if (n0 == 0) mode = 0;
      end
    endcase
  endfunction

  task automatic check_now(input string tag);
    int h;
    h = (q.size() > 0) ? q[0] : 0;
    chk({tag, ".tvalid"}, m_axis_tvalid, q.size() > 0);
    chk({tag, ".tdata"},  m_axis_tdata, h & 32'hFFFF);
    chk({tag, ".tlast"},  m_axis_tlast, (h >> 16) & 1);
    chk({tag, ".ovf"},    ovf_o, ovf_m);
    chk({tag, ".busy"},   busy_o, mode != 0);
    chk({tag, ".period"}, period_cnt_o, per_m);
  endtask

  task automatic drv(input bit e, input bit v, input bit b, input bit f, input int a, input bit r);
    logic [31:0] av;
    av            = a;
    en            = e;
    bit_vld_i     = v;
    bit_i         = b;
    flag_i        = f;
    amp_i         = av[DAC_W-2:0];
    m_axis_tready = r;
  endtask

  // Record a handshake, advance one edge, then compare against the model.
  task automatic cyc(input string tag);
    if (m_axis_tvalid && m_axis_tready)
      dut_out.push_back(int'({15'b0, m_axis_tlast, m_axis_tdata}));
    @(posedge clk);
    model_step();
    #1;
    check_now(tag);
  endtask

  task automatic do_reset();
    srst = 1'b1;
    drv(0, 0, 0, 0, 0, 0);
    model_reset();
    @(posedge clk);
    #1;
    srst = 1'b0;
    dut_out.delete();
    check_now("rst");
  endtask

  initial begin
    int e_r;
    // Power-on reset: outputs must be zero without any clock edge.
    srst = 1'b1;
    drv(0, 0, 0, 0, 0, 0);
    model_reset();
    #3;
    chk("por.tvalid", m_axis_tvalid, 0);
    chk("por.tdata",  m_axis_tdata, 0);
    chk("por.busy",   busy_o, 0);
    chk("por.period", period_cnt_o, 0);
    check_now("por");
    @(posedge clk);
    #1;
    srst = 1'b0;

    // T1: basic mapping, tlast and period count.
    dut_out.delete();
    drv(1, 0, 0, 0, 1000, 1); cyc("t1.start");
    drv(1, 1, 1, 0, 1000, 1); cyc("t1.c0");
    chk("t1.latency", m_axis_tvalid, 1);
    drv(1, 1, 0, 0, 1000, 1); cyc("t1.c1");
    drv(1, 1, 1, 1, 1000, 1); cyc("t1.c2");
    drv(1, 0, 0, 0, 1000, 1);
    repeat (3) cyc("t1.tail");
    chk("t1.count", dut_out.size(), 3);
    for (int i = 0; i < 3; i++)
      chk($sformatf("t1.s%0d", i), (i < dut_out.size()) ? dut_out[i] : -1, exp1[i]);
    chk("t1.period", period_cnt_o, 1);

    // T2: overflow with tready low, then exactly DEPTH samples drain in order.
    dut_out.delete();
    for (int i = 0; i < 9; i++) begin
      drv(1, 1, bit'(i % 2), 0, 1000, 0);
      cyc("t2.fill");
    end
    chk("t2.ovf", ovf_o, 1);
    drv(1, 0, 0, 0, 1000, 1);
    repeat (10) cyc("t2.drain");
    chk("t2.count", dut_out.size(), 8);
    for (int i = 0; i < 8; i++)
      chk($sformatf("t2.s%0d", i), (i < dut_out.size()) ? dut_out[i] : -1,
          (i % 2) ? 32'h003E8 : 32'h0FC18);
    chk("t2.ovf_sticky", ovf_o, 1);

    // T3: full FIFO, simultaneous pop and push is accepted without overflow.
    do_reset();
    drv(1, 0, 0, 0, 1000, 0); cyc("t3.start");
    for (int i = 0; i < 8; i++) begin
      drv(1, 1, 1, 0, 1000, 0);
      cyc("t3.fill");
    end
    drv(1, 1, 0, 0, 1000, 1); cyc("t3.swap");
    chk("t3.ovf_swap", ovf_o, 0);
    drv(1, 1, 1, 0, 1000, 0); cyc("t3.extra");
    chk("t3.ovf_extra", ovf_o, 1);
    drv(1, 0, 0, 0, 1000, 1);
    repeat (10) cyc("t3.drain");
    chk("t3.count", dut_out.size(), 9);

    // T4: amplitude change mid-period takes effect after the flagged chip.
    do_reset();
    drv(1, 0, 0, 0, 1000, 1); cyc("t4.start");
    drv(1, 1, 1, 0, 1000, 1); cyc("t4.c0");
    drv(1, 1, 1, 0, 1000, 1); cyc("t4.c1");
    drv(1, 1, 1, 0, 2000, 1); cyc("t4.c2");
    drv(1, 1, 1, 1, 2000, 1); cyc("t4.c3");
    drv(1, 1, 0, 0, 2000, 1); cyc("t4.c4");
    drv(1, 1, 1, 0, 2000, 1); cyc("t4.c5");
    drv(1, 0, 0, 0, 2000, 1);
    repeat (3) cyc("t4.tail");
    chk("t4.count", dut_out.size(), 6);
    for (int i = 0; i < 6; i++)
      chk($sformatf("t4.s%0d", i), (i < dut_out.size()) ? dut_out[i] : -1, exp4[i]);

    // T5: disabling with 5 entries queued drains them; strobes while disabled are ignored.
    do_reset();
    drv(1, 0, 0, 0, 500, 0); cyc("t5.start");
    for (int i = 0; i < 5; i++) begin
      drv(1, 1, bit'(i % 2), 0, 500, 0);
      cyc("t5.fill");
    end
    drv(0, 1, 1, 0, 500, 0);
    repeat (3) cyc("t5.hold");
    chk("t5.busy_drain", busy_o, 1);
    drv(0, 1, 1, 0, 500, 1);
    repeat (8) cyc("t5.drain");
    chk("t5.busy_idle", busy_o, 0);
    chk("t5.count", dut_out.size(), 5);
    chk("t5.ovf", ovf_o, 0);

    // T6: asynchronous reset with data queued; no stale samples afterwards.
    do_reset();
    drv(1, 0, 0, 0, 700, 0); cyc("t6.start");
    for (int i = 0; i < 3; i++) begin
      drv(1, 1, 1, 0, 700, 0);
      cyc("t6.fill");
    end
    #3;
    srst = 1'b1;
    #1;
    model_reset();
    chk("t6.tvalid", m_axis_tvalid, 0);
    chk("t6.tdata",  m_axis_tdata, 0);
    chk("t6.tlast",  m_axis_tlast, 0);
    chk("t6.busy",   busy_o, 0);
    @(posedge clk);
    #1;
    srst = 1'b0;
    dut_out.delete();
    drv(0, 0, 0, 0, 700, 1);
    repeat (4) cyc("t6.idle");
    drv(1, 0, 0, 0, 700, 1); cyc("t6.restart");
    drv(1, 1, 0, 0, 700, 1); cyc("t6.chip");
    drv(1, 0, 0, 0, 700, 1);
    repeat (3) cyc("t6.tail");
    chk("t6.count", dut_out.size(), 1);
    chk("t6.sample", (dut_out.size() > 0) ? dut_out[0] : -1, 32'h0FD44);

    // Randomized run: en in long runs, random chips, flags, amplitudes and backpressure.
    do_reset();
    e_r = 1;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 39) == 0) e_r = 1 - e_r;
      drv(bit'(e_r),
          bit'($urandom_range(0, 1)),
          bit'($urandom_range(0, 1)),
          $urandom_range(0, 5) == 0,
          ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(0, 8191)),
          $urandom_range(0, 2) != 0);
      cyc("rnd");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
